// File: rtl/host_req_arbiter_if.sv
// Bundle between the host-message arbiter and its requesters / NASTI write slave.
// master = arbiter side, slave = requesters plus NASTI host-message slave.
interface host_req_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int ADDR_WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [32*NREQ-1:0]    req_msg;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  clr_err;
  logic [15:0]           txn_count;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [USER_WIDTH-1:0] aw_user;
  logic                  w_valid;
  logic                  w_ready;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  w_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;

  modport master (
    input  req_valid, req_msg, clr_err, aw_ready, w_ready, b_valid, b_id, b_resp,
    output req_ready, done, err, txn_count,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_user,
    output w_valid, w_data, w_strb, w_last, b_ready
  );

  modport slave (
    output req_valid, req_msg, clr_err, aw_ready, w_ready, b_valid, b_id, b_resp,
    input  req_ready, done, err, txn_count,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_user,
    input  w_valid, w_data, w_strb, w_last, b_ready
  );
endinterface

// File: rtl/host_req_arbiter.sv
// Round-robin arbiter that serialises requester messages onto one single-beat
// NASTI write (AW, W, B), with per-requester done pulses and a sticky error flag.
module host_req_arbiter #(
  parameter int                    NREQ       = 4,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    USER_WIDTH = 1,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] HOST_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  host_req_arbiter_if.master   io_host
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_gnt;
  logic [31:0]       r_msg;
  logic              r_aw_valid;
  logic              r_w_valid;
  logic [NREQ-1:0]   r_done;
  logic              r_err;
  logic [15:0]       r_txn_count;

  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_cand;
  logic              w_any;
  int                w_idx;
  logic              w_acc;
  logic              w_b_ready;
  logic              w_complete;
  logic              w_bad;

  // Scan from farthest to nearest so the requester closest to r_ptr wins.
  always_comb begin
    w_sel  = r_ptr;
    w_cand = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_cand = PW'(w_idx);
      if (io_host.req_valid[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  assign w_acc      = rstn && (r_state == S_IDLE) && w_any;
  assign w_b_ready  = (r_state == S_W) ? io_host.w_ready : (r_state == S_B);
  assign w_complete = io_host.b_valid && w_b_ready;
  assign w_bad      = (io_host.b_resp != 2'b00) || (io_host.b_id != ID_WIDTH'(r_gnt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_txn_count <= '0;
    end else begin
      r_done <= '0;
      if (w_complete) begin
        r_done      <= NREQ'(1) << r_gnt;
        r_txn_count <= r_txn_count + 16'd1;
      end
      // A new error outranks a clear arriving in the same cycle.
      if (w_complete && w_bad) r_err <= 1'b1;
      else if (io_host.clr_err) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_sel;
            r_ptr      <= (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
            r_aw_valid <= 1'b1;
            r_state    <= S_AW;
          end
        end
        S_AW: begin
          if (io_host.aw_ready) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b1;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (io_host.w_ready) begin
            r_w_valid <= 1'b0;
            r_state   <= io_host.b_valid ? S_IDLE : S_B;
          end
        end
        S_B: begin
          if (io_host.b_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_msg <= io_host.req_msg[32*w_sel +: 32];
  end

  assign io_host.req_ready = w_acc ? (NREQ'(1) << w_sel) : '0;
  assign io_host.done      = r_done;
  assign io_host.err       = r_err;
  assign io_host.txn_count = r_txn_count;
  assign io_host.aw_valid  = r_aw_valid;
  assign io_host.aw_addr   = HOST_ADDR;
  assign io_host.aw_id     = ID_WIDTH'(r_gnt);
  assign io_host.aw_len    = 8'd0;
  assign io_host.aw_size   = 3'd2;
  assign io_host.aw_user   = '0;
  assign io_host.w_valid   = r_w_valid;
  assign io_host.w_data    = r_msg;
  assign io_host.w_strb    = 4'hF;
  assign io_host.w_last    = 1'b1;
  assign io_host.b_ready   = w_b_ready;

endmodule

// File: tb/tb_host_req_arbiter.sv
// Randomised scoreboard bench for host_req_arbiter: requesters and a NASTI slave
// are modelled here; a separate monitor checks every handshake and completion.
module tb_host_req_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  host_req_arbiter_if #(.NREQ(NREQ), .ID_WIDTH(IDW), .USER_WIDTH(1), .ADDR_WIDTH(32)) bus();

  host_req_arbiter #(
    .NREQ(NREQ), .ID_WIDTH(IDW), .USER_WIDTH(1), .ADDR_WIDTH(32), .HOST_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .io_host(bus)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Stimulus-side reference model and knobs
  int   m_ptr = 0;
  bit   m_busy = 0;
  int   acc_cnt = 0;
  int   req_pct = 0, rdy_pct = 100, sameb_pct = 100, err_pct = 0, clr_pct = 0;
  bit   gen_on = 0, hold_mode = 0, drop_on = 0;
  bit   pend_b = 0;
  int   b_dly = 0;
  logic [IDW-1:0] s_aw_id = '0;
  bit   s_req_hs, s_w_hs, s_b_hs;
  int   s_win;

  task automatic raise_b();
    int r;
    bus.b_valid = 1'b1;
    bus.b_id    = s_aw_id;
    bus.b_resp  = 2'b00;
    if ($urandom_range(0, 99) < err_pct) begin
      r = $urandom_range(0, 2);
      if (r != 1) bus.b_resp = 2'b10;
      if (r != 0) bus.b_id = s_aw_id ^ IDW'(1);
    end
  endtask

  task automatic drive();
    if (s_b_hs) bus.b_valid = 1'b0;
    if (s_w_hs && !s_b_hs) begin
      pend_b = 1'b1;
      b_dly  = $urandom_range(0, 4);
    end
    if (pend_b) begin
      if (b_dly == 0) begin
        raise_b();
        pend_b = 1'b0;
      end else b_dly--;
    end else if (!bus.b_valid && bus.w_valid && $urandom_range(0, 99) < sameb_pct) begin
      raise_b();
    end
    bus.aw_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.w_ready  = ($urandom_range(0, 99) < rdy_pct);
    bus.clr_err  = ($urandom_range(0, 99) < clr_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (s_req_hs && s_win == i) begin
        if (hold_mode) bus.req_msg[32*i +: 32] = 32'($urandom);
        else bus.req_valid[i] = 1'b0;
      end else if (bus.req_valid[i] && drop_on && $urandom_range(0, 9) == 0) begin
        bus.req_valid[i] = 1'b0;
      end
      if (!bus.req_valid[i] && gen_on && $urandom_range(0, 99) < req_pct) begin
        bus.req_valid[i] = 1'b1;
        bus.req_msg[32*i +: 32] = 32'($urandom);
      end
    end
  endtask

  // One clock: observe handshakes on the falling edge, then drive after the rising edge.
  task automatic step();
    logic [NREQ-1:0] exp_rr;
    @(negedge clk);
    s_req_hs = 0; s_w_hs = 0; s_b_hs = 0; s_win = -1;
    if (rstn) begin
      exp_rr = '0;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (bus.req_valid[c]) begin
            s_win = c;
            break;
          end
        end
      end
      if (s_win >= 0) exp_rr[s_win] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
      if (bus.req_ready != '0 && s_win >= 0) begin
        txn_t t;
        s_req_hs = 1;
        t.id   = s_win;
        t.data = bus.req_msg[32*s_win +: 32];
        exp_q.push_back(t);
        m_ptr  = (s_win + 1) % NREQ;
        m_busy = 1;
        acc_cnt++;
      end
      if (bus.aw_valid && bus.aw_ready) s_aw_id = bus.aw_id;
      s_w_hs = bus.w_valid && bus.w_ready;
      s_b_hs = bus.b_valid && bus.b_ready;
      if (s_b_hs) m_busy = 0;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ptr = 0; m_busy = 0; pend_b = 0; acc_cnt = 0;
    s_req_hs = 0; s_w_hs = 0; s_b_hs = 0; s_win = -1;
    bus.b_valid = 1'b0; bus.b_id = '0; bus.b_resp = 2'b00;
    bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    gen_on = 0; hold_mode = 0; drop_on = 0;
    bus.req_valid = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    int n;
    gen_on = 0; hold_mode = 0;
    n = 0;
    while ((m_busy || bus.req_valid != '0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_busy", 64'(m_busy), 64'd0);
  endtask

  // Monitor: scoreboard pops and per-cycle output checks
  logic [NREQ-1:0] exp_done = '0;
  logic [15:0]     m_txn = '0;
  bit              m_err = 0;
  bit              in_w = 0, await_b = 0;
  bit              prev_aw_stall = 0, prev_w_stall = 0;
  logic [IDW-1:0]  prev_aw_id = '0;
  logic [31:0]     prev_w_data = '0;
  int              done_cnt[NREQ];
  bit              mb_hs, mb_bad;

  initial for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_done = '0; m_txn = '0; m_err = 0; in_w = 0; await_b = 0;
      prev_aw_stall = 0; prev_w_stall = 0;
    end else begin
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("txn_count", 64'(bus.txn_count), 64'(m_txn));
      chk("err", 64'(bus.err), 64'(m_err));
      chk("w_valid", 64'(bus.w_valid), 64'(in_w));
      chk("b_ready", 64'(bus.b_ready), 64'(in_w ? bus.w_ready : await_b));
      for (int i = 0; i < NREQ; i++) if (bus.done[i]) done_cnt[i]++;
      if (prev_aw_stall) begin
        chk("aw_hold_valid", 64'(bus.aw_valid), 64'd1);
        chk("aw_hold_id", 64'(bus.aw_id), 64'(prev_aw_id));
      end
      if (prev_w_stall) chk("w_hold_data", 64'(bus.w_data), 64'(prev_w_data));

      if (bus.aw_valid && bus.aw_ready) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 64'(bus.aw_valid), 64'd0);
        else begin
          chk("aw_id", 64'(bus.aw_id), 64'(exp_q[0].id));
          chk("aw_fixed", {bus.aw_addr, 16'(bus.aw_len), 13'(bus.aw_size), 3'(bus.aw_user)},
              {32'h0, 16'd0, 13'd2, 3'd0});
        end
        in_w = 1;
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() != 0) chk("w_data", 64'(bus.w_data), 64'(exp_q[0].data));
        chk("w_fixed", 64'({bus.w_strb, bus.w_last}), 64'h1F);
        in_w = 0;
      end
      mb_hs  = bus.b_valid && bus.b_ready;
      mb_bad = 0;
      exp_done = '0;
      if (mb_hs) begin
        if (exp_q.size() == 0) chk("b_unexpected", 64'(mb_hs), 64'd0);
        else begin
          mb_bad = (bus.b_resp != 2'b00) || (int'(bus.b_id) != exp_q[0].id);
          exp_done[exp_q[0].id] = 1'b1;
          void'(exp_q.pop_front());
        end
        m_txn   = m_txn + 16'd1;
        await_b = 0;
      end else if (bus.w_valid && bus.w_ready) begin
        await_b = 1;
      end
      m_err = mb_bad ? 1'b1 : (bus.clr_err ? 1'b0 : m_err);
      prev_aw_stall = bus.aw_valid && !bus.aw_ready;
      prev_aw_id    = bus.aw_id;
      prev_w_stall  = bus.w_valid && !bus.w_ready;
      prev_w_data   = bus.w_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc0[NREQ];
    bus.req_valid = '0; bus.req_msg = '0; bus.clr_err = 1'b0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_id = '0; bus.b_resp = 2'b00;
    do_reset();

    // Single request from requester 2, fully ready slave with same-cycle B
    rdy_pct = 100; sameb_pct = 100; err_pct = 0; clr_pct = 0;
    bus.req_valid[2] = 1'b1;
    bus.req_msg[32*2 +: 32] = 32'h0001_0041;
    n = 0;
    while (acc_cnt == 0 && n < 20) begin step(); n++; end
    chk("single_accept", 64'(acc_cnt), 64'd1);
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end
    chk("single_latency", 64'(n), 64'd2);
    drain();

    // All requesters held valid for eight messages from a fresh pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) dc0[i] = done_cnt[i];
    hold_mode = 1; gen_on = 1; req_pct = 100;
    n = 0;
    while (acc_cnt < 8 && n < 100) begin step(); n++; end
    hold_mode = 0; gen_on = 0; bus.req_valid = '0;
    drain();
    step(); step();
    for (int i = 0; i < NREQ; i++) chk("hold_done_count", 64'(done_cnt[i] - dc0[i]), 64'd2);

    // Random traffic with back-pressure, late responses and request drops
    rdy_pct = 30; sameb_pct = 50; req_pct = 40; drop_on = 1; gen_on = 1;
    repeat (300) step();
    drain();

    // Error responses mixed with random clears
    rdy_pct = 70; err_pct = 30; clr_pct = 20; gen_on = 1;
    repeat (400) step();
    drain();
    clr_pct = 0; err_pct = 0; drop_on = 0;
    step(); step();

    // Reset while the write data beat is pending
    gen_on = 1; req_pct = 60; rdy_pct = 60; sameb_pct = 0;
    n = 0;
    while (!bus.w_valid && n < 100) begin step(); n++; end
    chk("reach_w", 64'(bus.w_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("rst_aw_valid", 64'(bus.aw_valid), 64'd0);
    chk("rst_txn_count", 64'(bus.txn_count), 64'd0);
    chk("rst_done_err", 64'({bus.done, bus.err}), 64'd0);
    gen_on = 0;
    model_clear();
    bus.req_valid = 4'b1010;
    bus.req_msg[32*1 +: 32] = 32'h0001_1111;
    bus.req_msg[32*3 +: 32] = 32'h0003_3333;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    rdy_pct = 100; sameb_pct = 100;
    n = 0;
    while (acc_cnt == 0 && n < 20) begin step(); n++; end
    chk("post_rst_first_grant", 64'(s_win), 64'd1);
    drain();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
